// File: rtl/oc_pkg.sv
// Shared types and sizing helpers for the overcurrent supervisor.
package oc_pkg;

  typedef enum logic {
    MONITOR = 1'b0,
    TRIPPED = 1'b1
  } oc_state_e;

  // 200 ms qualification and 500 ms cooldown on the 100 MHz board clock
  localparam int DEF_TRIP_CYCLES  = 20_000_000;
  localparam int DEF_RETRY_CYCLES = 50_000_000;

  function automatic int cnt_width(input int trip_cycles, input int retry_cycles);
    int m;
    m = (trip_cycles > retry_cycles) ? trip_cycles : retry_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/oc_channel.sv
// One overcurrent channel: 2-flop synchroniser, qualification/cooldown counter and fault FSM.
//   state   | meaning
//   MONITOR | armed; counting consecutive synchronised-high cycles toward a trip
//   TRIPPED | fault latched; waiting for clear (or cooldown expiry in auto-retry mode)
module oc_channel
  import oc_pkg::*;
#(
  parameter int TRIP_CYCLES  = DEF_TRIP_CYCLES,
  parameter int AUTO_RETRY   = 0,
  parameter int RETRY_CYCLES = DEF_RETRY_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic oc_in,
  input  logic clear,
  input  logic ch_en,
  output logic oc_fault,
  output logic trip_seen
);

  localparam int CNT_W = cnt_width(TRIP_CYCLES, RETRY_CYCLES);
  localparam logic [CNT_W-1:0] TRIP_LAST  = CNT_W'(TRIP_CYCLES - 1);
  localparam logic [CNT_W-1:0] RETRY_LAST = CNT_W'(RETRY_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             oc_s_q, oc_s_d;
  oc_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             seen_q, seen_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b0;
      oc_s_q  <= 1'b0;
      state_q <= MONITOR;
      cnt_q   <= '0;
      seen_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      oc_s_q  <= oc_s_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
    end
  end

  always_comb begin
    sync1_d = oc_in;
    oc_s_d  = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    seen_d  = seen_q;

    if (!ch_en) begin
      state_d = MONITOR;
      cnt_d   = '0;
    end else begin
      case (state_q)
        MONITOR: begin
          if (oc_s_q) begin
            if (cnt_q == TRIP_LAST) begin
              state_d = TRIPPED;
              seen_d  = 1'b1;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            cnt_d = '0;
          end
        end
        TRIPPED: begin
          // clear wins over the cooldown; both re-arm with a fresh qualification
          if (clear) begin
            state_d = MONITOR;
            cnt_d   = '0;
          end else if (AUTO_RETRY != 0) begin
            if (cnt_q == RETRY_LAST) begin
              state_d = MONITOR;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = MONITOR;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign oc_fault  = (state_q == TRIPPED);
  assign trip_seen = seen_q;

endmodule

// File: rtl/oc_monitor.sv
// Multi-channel overcurrent supervisor: per-channel trip latches gating the motor enables.
module oc_monitor
  import oc_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int TRIP_CYCLES  = DEF_TRIP_CYCLES,
  parameter int AUTO_RETRY   = 0,
  parameter int RETRY_CYCLES = DEF_RETRY_CYCLES
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] oc_in,
  input  logic              clear,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] oc_fault,
  output logic              oc_any,
  output logic [NUM_CH-1:0] motor_en,
  output logic [NUM_CH-1:0] trip_seen
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    oc_channel #(
      .TRIP_CYCLES  (TRIP_CYCLES),
      .AUTO_RETRY   (AUTO_RETRY),
      .RETRY_CYCLES (RETRY_CYCLES)
    ) u_ch (
      .clock     (clock),
      .reset     (reset),
      .oc_in     (oc_in[i]),
      .clear     (clear),
      .ch_en     (ch_en[i]),
      .oc_fault  (oc_fault[i]),
      .trip_seen (trip_seen[i])
    );
  end

  assign oc_any = |oc_fault;

  // drivers stay off while reset is held, then follow ch_en immediately
  assign motor_en = ch_en & ~oc_fault & {NUM_CH{~reset}};

endmodule

// File: tb/tb_oc_monitor.sv
// Bench for oc_monitor: latched (dut_a) and auto-retry (dut_r) instances with a per-cycle scoreboard.
module tb_oc_monitor;

  localparam int NCH   = 2;
  localparam int TRIP  = 8;
  localparam int RETRY = 16;

  logic clock = 1'b0;
  logic reset;
  logic [NCH-1:0] oc_a, en_a, oc_r, en_r;
  logic clr_a, clr_r;
  logic [NCH-1:0] fault_a, motor_a, seen_a, fault_r, motor_r, seen_r;
  logic any_a, any_r;
  logic [13:0] obs;

  int checks = 0;
  int errors = 0;
  logic [13:0] exp_q[$];

  always #5 clock = ~clock;

  oc_monitor #(.NUM_CH(NCH), .TRIP_CYCLES(TRIP), .AUTO_RETRY(0), .RETRY_CYCLES(RETRY)) dut_a (
    .clock(clock), .reset(reset), .oc_in(oc_a), .clear(clr_a), .ch_en(en_a),
    .oc_fault(fault_a), .oc_any(any_a), .motor_en(motor_a), .trip_seen(seen_a)
  );

  oc_monitor #(.NUM_CH(NCH), .TRIP_CYCLES(TRIP), .AUTO_RETRY(1), .RETRY_CYCLES(RETRY)) dut_r (
    .clock(clock), .reset(reset), .oc_in(oc_r), .clear(clr_r), .ch_en(en_r),
    .oc_fault(fault_r), .oc_any(any_r), .motor_en(motor_r), .trip_seen(seen_r)
  );

  assign obs = {fault_a, any_a, motor_a, seen_a, fault_r, any_r, motor_r, seen_r};

  // expected {fault, any, motor_en, trip_seen} for one instance; en is the effective gate
  function automatic logic [6:0] mk(input logic [1:0] f, input logic [1:0] en, input logic [1:0] s);
    return {f, |f, en & ~f, s};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [13:0] e;
    reset = 1'b1; en_a = 2'b11; en_r = 2'b11;
    oc_a = 2'b00; oc_r = 2'b00; clr_a = 1'b0; clr_r = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) reset = 1'b0;
      if (i < 3) exp_q.push_back({mk(2'b00, 2'b00, 2'b00), mk(2'b00, 2'b00, 2'b00)});
      else       exp_q.push_back({mk(2'b00, 2'b11, 2'b00), mk(2'b00, 2'b11, 2'b00)});
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset i=%0d got=%b exp=%b", i, obs, e);
      end
    end
  endtask

  task automatic test_trip();
    logic [13:0] e;
    logic [1:0] f;
    oc_a = 2'b01;
    for (int i = 0; i < 14; i++) begin
      f = (i >= TRIP + 1) ? 2'b01 : 2'b00;
      exp_q.push_back({mk(f, 2'b11, f), mk(2'b00, 2'b11, 2'b00)});
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL trip i=%0d got=%b exp=%b", i, obs, e);
      end
    end
    oc_a = 2'b00;
    for (int i = 0; i < 5; i++) begin
      clr_a = (i == 0);
      exp_q.push_back({mk(2'b00, 2'b11, 2'b01), mk(2'b00, 2'b11, 2'b00)});
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL trip_release i=%0d got=%b exp=%b", i, obs, e);
      end
    end
    clr_a = 1'b0;
  endtask

  task automatic test_requalify();
    logic [13:0] e;
    logic [1:0] f;
    for (int i = 0; i < 30; i++) begin
      oc_a = (i == 7 || i == 15) ? 2'b00 : 2'b01;
      f = (i >= 16 + TRIP + 1) ? 2'b01 : 2'b00;
      exp_q.push_back({mk(f, 2'b11, 2'b01), mk(2'b00, 2'b11, 2'b00)});
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL requalify i=%0d got=%b exp=%b", i, obs, e);
      end
    end
  endtask

  task automatic test_clear_retrip();
    logic [13:0] e;
    logic [1:0] f;
    for (int i = 0; i < 12; i++) begin
      clr_a = (i == 0);
      f = (i >= TRIP) ? 2'b01 : 2'b00;
      exp_q.push_back({mk(f, 2'b11, 2'b01), mk(2'b00, 2'b11, 2'b00)});
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL clear_retrip i=%0d got=%b exp=%b", i, obs, e);
      end
    end
    clr_a = 1'b0;
  endtask

  task automatic test_clear_held();
    logic [13:0] e;
    logic [1:0] f;
    clr_a = 1'b1;
    for (int i = 0; i < 27; i++) begin
      f = ((i % (TRIP + 1)) == TRIP) ? 2'b01 : 2'b00;
      exp_q.push_back({mk(f, 2'b11, 2'b01), mk(2'b00, 2'b11, 2'b00)});
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL clear_held i=%0d got=%b exp=%b", i, obs, e);
      end
    end
    oc_a = 2'b00;
    for (int i = 0; i < 6; i++) begin
      clr_a = (i < 3);
      exp_q.push_back({mk(2'b00, 2'b11, 2'b01), mk(2'b00, 2'b11, 2'b00)});
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL clear_held_release i=%0d got=%b exp=%b", i, obs, e);
      end
    end
    clr_a = 1'b0;
  endtask

  task automatic test_auto_retry();
    logic [13:0] e;
    logic [1:0] f, s;
    for (int i = 0; i < 30; i++) begin
      oc_r = (i < 10) ? 2'b10 : 2'b00;
      f = (i >= TRIP + 1 && i < TRIP + 1 + RETRY) ? 2'b10 : 2'b00;
      s = (i >= TRIP + 1) ? 2'b10 : 2'b00;
      exp_q.push_back({mk(2'b00, 2'b11, 2'b01), mk(f, 2'b11, s)});
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL auto_retry i=%0d got=%b exp=%b", i, obs, e);
      end
    end
  endtask

  task automatic test_simultaneous_reset();
    logic [13:0] e;
    logic [1:0] f, s;
    for (int i = 0; i < 17; i++) begin
      if (i < 12) begin
        oc_a = 2'b11;
        f = (i >= TRIP + 1) ? 2'b11 : 2'b00;
        s = (i >= TRIP + 1) ? 2'b11 : 2'b01;
        exp_q.push_back({mk(f, 2'b11, s), mk(2'b00, 2'b11, 2'b10)});
      end else if (i < 14) begin
        reset = 1'b1;
        oc_a = 2'b00;
        exp_q.push_back({mk(2'b00, 2'b00, 2'b00), mk(2'b00, 2'b00, 2'b00)});
      end else begin
        reset = 1'b0;
        exp_q.push_back({mk(2'b00, 2'b11, 2'b00), mk(2'b00, 2'b11, 2'b00)});
      end
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL simul_reset i=%0d got=%b exp=%b", i, obs, e);
      end
    end
  endtask

  task automatic test_ch_en();
    logic [13:0] e;
    logic [1:0] f, s;
    oc_a = 2'b10;
    for (int i = 0; i < 64; i++) begin
      en_a = (i >= 50 && i < 60) ? 2'b11 : 2'b01;
      f = (i >= 50 + TRIP - 1 && i < 60) ? 2'b10 : 2'b00;
      s = (i >= 50 + TRIP - 1) ? 2'b10 : 2'b00;
      exp_q.push_back({mk(f, en_a, s), mk(2'b00, 2'b11, 2'b00)});
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL ch_en i=%0d got=%b exp=%b", i, obs, e);
      end
    end
    oc_a = 2'b00;
    en_a = 2'b11;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_trip();
    test_requalify();
    test_clear_retrip();
    test_clear_held();
    test_auto_retry();
    test_simultaneous_reset();
    test_ch_en();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/oc_monitor.md
Name: oc_monitor

Overview:
Multi-channel overcurrent supervisor for the motor drivers. Each channel has three stages:
- synchronises its comparator input;
- debounces it with a qualification counter;
- latches a fault and drops that channel's motor enable.

Faults clear from the operator clear button, or by timed auto-retry when that mode is selected. Sits between the analog comparator pins and the PWM/motor-enable logic.

Parameters:
NUM_CH, 2, number of monitored channels (motors); 1..8
TRIP_CYCLES, 20000000, consecutive synchronised-high cycles needed to trip; >=1
AUTO_RETRY, 0, 0 = latch until clear; 1 = self-clear after RETRY_CYCLES
RETRY_CYCLES, 50000000, cooldown cycles in TRIPPED before auto re-arm (AUTO_RETRY=1 only); >=1
CNT_W, localparam, clog2(max(TRIP_CYCLES,RETRY_CYCLES)+1)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
oc_in  in  NUM_CH  raw comparator outputs, asynchronous, 1 = overcurrent
clear  in  1  operator clear (debounced level), active-high
ch_en  in  NUM_CH  channel enable; 0 = channel ignored and held disarmed
oc_fault  out  NUM_CH  latched fault per channel
oc_any  out  1  OR of oc_fault
motor_en  out  NUM_CH  gate to drivers: ch_en & ~oc_fault
trip_seen  out  NUM_CH  sticky "has tripped since reset"; cleared only by reset

Behaviour:
- Reset values:
  - oc_fault=0, oc_any=0, trip_seen=0, motor_en=0;
  - all counters=0, all FSMs=MONITOR, synchroniser flops=0.
  - motor_en follows ch_en from the first cycle after reset.
- Synchroniser: 2-flop per channel; oc_s[i] is oc_in[i] delayed 2 clocks.
- Per-channel FSM, states MONITOR, TRIPPED:
  - MONITOR, oc_s=1: cnt<=cnt+1. When cnt==TRIP_CYCLES-1 and oc_s=1: go to TRIPPED, oc_fault<=1, trip_seen<=1, cnt<=0.
  - MONITOR, oc_s=0: cnt<=0. Any single low cycle restarts qualification.
  - Trip timing: oc_fault rises exactly TRIP_CYCLES+2 clocks after oc_in rises and is held high. It is registered, so it is visible on the clock edge after the qualifying cycle.
  - TRIPPED, AUTO_RETRY=0: stay until clear=1, then go to MONITOR, oc_fault<=0, cnt<=0. oc_in is ignored while TRIPPED.
  - TRIPPED, AUTO_RETRY=1: cnt counts every cycle. At cnt==RETRY_CYCLES-1, or on clear=1 (whichever first), go to MONITOR, oc_fault<=0, cnt<=0.
- Clear with overcurrent still present: channel re-arms and re-qualifies from 0. It must not re-trip in fewer than TRIP_CYCLES cycles.
- clear in MONITOR: no effect. If clear is held high continuously, a trip still latches for 1 cycle and then releases on the next cycle. Fault pulse width is 1 cycle.
- ch_en[i]=0:
  - forces MONITOR, cnt=0, oc_fault[i]=0 on the next edge;
  - trip_seen[i] is unaffected.
- Simultaneous trips on multiple channels are independent and all latch in the same cycle.
- oc_any and motor_en are combinational from registered state; no extra latency.
- Counters never wrap: terminal compares end every count before overflow.
- Reset mid-count or mid-TRIPPED returns everything to reset values on that edge.

Decomposition:
- Package oc_pkg:
  - state enum {MONITOR, TRIPPED};
  - CNT_W computation function;
  - default TRIP/RETRY constants for the 100 MHz board.
- Sub-module oc_channel: synchroniser, counter and FSM for one channel, with parameters TRIP_CYCLES/AUTO_RETRY/RETRY_CYCLES.
- Top level: generate-loops NUM_CH instances and forms oc_any/motor_en.

Test Plan:
(Bench parameters: NUM_CH=2, TRIP_CYCLES=8, RETRY_CYCLES=16.)
1. oc_in[0]=1 held, ch_en=2'b11, AUTO_RETRY=0 -> oc_fault[0] rises 10 clocks after oc_in edge; motor_en=2'b10; oc_any=1; trip_seen[0]=1; ch1 unaffected.
2. oc_in[0] high 7 cycles, low 1, high 7 -> no trip; then high 8 -> trip at cycle 8+2 of final run.
3. Tripped ch0, oc_in still 1, pulse clear 1 cycle -> oc_fault[0]=0 next edge, re-trips exactly 8 cycles later; trip_seen stays 1.
4. AUTO_RETRY=1, trip ch1, oc_in[1]=0 -> oc_fault[1] deasserts exactly 16 cycles after rising, no clear needed.
5. Both channels trip on the same cycle; then reset asserted mid-TRIPPED -> all outputs 0 next edge, motor_en=ch_en after reset release.
6. ch_en[1]=0 while oc_in[1]=1 for 50 cycles -> oc_fault[1] never asserts, motor_en[1]=0; re-enable -> trips 8 cycles later.
